// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU loader slice -- width defaults,
// opcode encodings, FSM state encodings and button bit positions.
package alu_pkg;

   localparam int unsigned LEN_DATO_DEF = 8;
   localparam int unsigned LEN_OP_DEF   = 6;
   localparam int unsigned OP_W         = 6;
   localparam int unsigned BTN_W        = 3;

   // Button bit positions on i_btn
   localparam int unsigned BTN_A  = 2;
   localparam int unsigned BTN_B  = 1;
   localparam int unsigned BTN_OP = 0;

   // Opcodes, zero-extended to LEN_OP where they are used
   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;

   typedef enum logic [1:0] {
      WAIT_A  = 2'b00,
      WAIT_B  = 2'b01,
      WAIT_OP = 2'b10,
      DONE    = 2'b11
   } state_t;

endpackage

// File: rtl/alu_loader_if.sv
// alu_loader_if: groups the switch/button inputs and result outputs of the
// ALU loader. Flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_loader_if
   import alu_pkg::*;
#(
   parameter int unsigned LEN_DATO = LEN_DATO_DEF
) ();

   logic [LEN_DATO-1:0] switch;
   logic [BTN_W-1:0]    btn;
   logic [LEN_DATO-1:0] led;
   logic                valid;
   logic [1:0]          state;
`ifdef ALU_FLAGS_EN
   logic                zero;
   logic                carry;
`endif

   // Stimulus side: drives switches and buttons
   modport master (
      output switch, output btn,
      input  led, input valid, input state
`ifdef ALU_FLAGS_EN
      , input zero, input carry
`endif
   );

   // Loader side: consumes switches and buttons, produces results
   modport slave (
      input  switch, input btn,
      output led, output valid, output state
`ifdef ALU_FLAGS_EN
      , output zero, output carry
`endif
   );

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU. Unknown opcodes give 0.
// Carry/borrow output exists only when ALU_FLAGS_EN is defined.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned LEN_DATO = LEN_DATO_DEF,
   parameter int unsigned LEN_OP   = LEN_OP_DEF
) (
   input  logic [LEN_DATO-1:0] a,
   input  logic [LEN_DATO-1:0] b,
   input  logic [LEN_OP-1:0]   op,
   output logic [LEN_DATO-1:0] result_c
`ifdef ALU_FLAGS_EN
   ,
   output logic                carry_c
`endif
);

   localparam logic [LEN_OP-1:0] ADD_C = LEN_OP'(OP_ADD);
   localparam logic [LEN_OP-1:0] SUB_C = LEN_OP'(OP_SUB);
   localparam logic [LEN_OP-1:0] AND_C = LEN_OP'(OP_AND);
   localparam logic [LEN_OP-1:0] OR_C  = LEN_OP'(OP_OR);
   localparam logic [LEN_OP-1:0] XOR_C = LEN_OP'(OP_XOR);
   localparam logic [LEN_OP-1:0] NOR_C = LEN_OP'(OP_NOR);
   localparam logic [LEN_OP-1:0] SRL_C = LEN_OP'(OP_SRL);
   localparam logic [LEN_OP-1:0] SRA_C = LEN_OP'(OP_SRA);

   // Opcode decode; shifts by >= LEN_DATO saturate to 0 / sign fill naturally
   always_comb begin
      result_c = '0;
`ifdef ALU_FLAGS_EN
      carry_c  = 1'b0;
`endif
      case (op)
         ADD_C: begin
`ifdef ALU_FLAGS_EN
            {carry_c, result_c} = {1'b0, a} + {1'b0, b};
`else
            result_c = a + b;
`endif
         end
         SUB_C: begin
            result_c = a - b;
`ifdef ALU_FLAGS_EN
            carry_c  = (a < b);
`endif
         end
         AND_C:   result_c = a & b;
         OR_C:    result_c = a | b;
         XOR_C:   result_c = a ^ b;
         NOR_C:   result_c = ~(a | b);
         SRL_C:   result_c = b >> a;
         SRA_C:   result_c = $signed(b) >>> a;
         default: result_c = '0;
      endcase
   end

endmodule

// File: rtl/alu_loader.sv
// alu_loader: loads A, B and opcode from switches on debounced-by-sync button
// edges, sequences WAIT_A -> WAIT_B -> WAIT_OP -> DONE, and registers the ALU
// result. Define ALU_FLAGS_EN to add registered o_zero / o_carry outputs.
module alu_loader
   import alu_pkg::*;
#(
   parameter int unsigned LEN_DATO = LEN_DATO_DEF,
   parameter int unsigned LEN_OP   = LEN_OP_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [LEN_DATO-1:0] i_switch,
   input  logic [BTN_W-1:0]    i_btn,
   output logic [LEN_DATO-1:0] o_led,
   output logic                o_valid,
   output logic [1:0]          o_state
`ifdef ALU_FLAGS_EN
   ,
   output logic                o_zero,
   output logic                o_carry
`endif
);

   logic [BTN_W-1:0]    btn_meta;
   logic [BTN_W-1:0]    btn_sync;
   logic [BTN_W-1:0]    btn_prev;
   logic [BTN_W-1:0]    load_c;
   logic                ld_a_c;
   logic                ld_b_c;
   logic                ld_op_c;
   logic [LEN_DATO-1:0] a_q;
   logic [LEN_DATO-1:0] b_q;
   logic [LEN_OP-1:0]   op_q;
   logic [LEN_DATO-1:0] alu_result_c;
   state_t              state_q;
   state_t              state_d;
`ifdef ALU_FLAGS_EN
   logic                alu_carry_c;
`endif

   // Two-flop synchronizer plus previous-value flop for edge detection
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         btn_meta <= '0;
         btn_sync <= '0;
         btn_prev <= '0;
      end else begin
         btn_meta <= i_btn;
         btn_sync <= btn_meta;
         btn_prev <= btn_sync;
      end
   end

   assign load_c = btn_sync & ~btn_prev;

   // Priority A > B > opcode; losers in the same cycle are dropped
   always_comb begin
      ld_a_c  = load_c[BTN_A];
      ld_b_c  = load_c[BTN_B] & ~load_c[BTN_A];
      ld_op_c = load_c[BTN_OP] & ~load_c[BTN_A] & ~load_c[BTN_B];
   end

   // Operand and opcode registers, loadable in every state
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= '0;
      end else begin
         if (ld_a_c)  a_q  <= i_switch;
         if (ld_b_c)  b_q  <= i_switch;
         if (ld_op_c) op_q <= i_switch[LEN_OP-1:0];
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= WAIT_A;
      else          state_q <= state_d;
   end

   // FSM next state: advance only on the awaited load
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_A:  if (ld_a_c)  state_d = WAIT_B;
         WAIT_B:  if (ld_b_c)  state_d = WAIT_OP;
         WAIT_OP: if (ld_op_c) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = WAIT_A;
      endcase
   end

   alu_core #(
      .LEN_DATO (LEN_DATO),
      .LEN_OP   (LEN_OP)
   ) u_alu_core (
      .a        (a_q),
      .b        (b_q),
      .op       (op_q),
      .result_c (alu_result_c)
`ifdef ALU_FLAGS_EN
      ,
      .carry_c  (alu_carry_c)
`endif
   );

   // Result, valid and flags registered together from the current registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_led   <= '0;
         o_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
         o_zero  <= 1'b0;
         o_carry <= 1'b0;
`endif
      end else begin
         o_led   <= alu_result_c;
         o_valid <= (state_q == DONE);
`ifdef ALU_FLAGS_EN
         o_zero  <= (alu_result_c == '0);
         o_carry <= alu_carry_c;
`endif
      end
   end

   assign o_state = state_q;

endmodule

// File: tb/tb_alu_loader.sv
// tb_alu_loader: directed scoreboard bench for alu_loader at LEN_DATO=8 and
// LEN_DATO=16/LEN_OP=8. Flag checks are active when ALU_FLAGS_EN is defined.
module tb_alu_loader;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   alu_loader_if #(.LEN_DATO(8))  bus   ();
   alu_loader_if #(.LEN_DATO(16)) bus16 ();

   alu_loader #(.LEN_DATO(8), .LEN_OP(6)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_switch (bus.switch),
      .i_btn    (bus.btn),
      .o_led    (bus.led),
      .o_valid  (bus.valid),
      .o_state  (bus.state)
`ifdef ALU_FLAGS_EN
      ,
      .o_zero   (bus.zero),
      .o_carry  (bus.carry)
`endif
   );

   alu_loader #(.LEN_DATO(16), .LEN_OP(8)) dut16 (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_switch (bus16.switch),
      .i_btn    (bus16.btn),
      .o_led    (bus16.led),
      .o_valid  (bus16.valid),
      .o_state  (bus16.state)
`ifdef ALU_FLAGS_EN
      ,
      .o_zero   (bus16.zero),
      .o_carry  (bus16.carry)
`endif
   );

   typedef struct {
      int          cyc;
      bit          sel;
      logic [15:0] led;
      logic        valid;
      logic [1:0]  state;
      logic        zero;
      logic        carry;
      string       name;
   } exp_t;

   exp_t sb[$];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare each scoreboard entry when its due cycle arrives
   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            automatic exp_t e = sb.pop_front();
            automatic logic [15:0] a_led   = e.sel ? bus16.led   : 16'(bus.led);
            automatic logic        a_valid = e.sel ? bus16.valid : bus.valid;
            automatic logic [1:0]  a_state = e.sel ? bus16.state : bus.state;
            if (e.cyc < cyc) begin
               check({e.name, ".missed"}, 32'(cyc), 32'(e.cyc));
            end else begin
               check({e.name, ".led"},   32'(a_led),   32'(e.led));
               check({e.name, ".valid"}, 32'(a_valid), 32'(e.valid));
               check({e.name, ".state"}, 32'(a_state), 32'(e.state));
`ifdef ALU_FLAGS_EN
               check({e.name, ".zero"},  32'(e.sel ? bus16.zero  : bus.zero),  32'(e.zero));
               check({e.name, ".carry"}, 32'(e.sel ? bus16.carry : bus.carry), 32'(e.carry));
`endif
            end
         end
      end
   end

   task automatic expect_at(int dt, bit sel, logic [15:0] led, logic valid,
                            logic [1:0] st, logic z, logic c, string name);
      exp_t e;
      e.cyc = cyc + dt; e.sel = sel; e.led = led; e.valid = valid;
      e.state = st; e.zero = z; e.carry = c; e.name = name;
      sb.push_back(e);
   endtask

   // Press buttons b with switches sw at a falling edge; result due 4 cycles later
   task automatic press(bit sel, logic [2:0] b, logic [15:0] sw, logic [15:0] led,
                        logic valid, logic [1:0] st, logic z, logic c, string name);
      if (sel) begin bus16.switch = sw; bus16.btn = b; end
      else     begin bus.switch = 8'(sw); bus.btn = b; end
      expect_at(4, sel, led, valid, st, z, c, name);
      repeat (4) @(negedge clk);
      bus.btn = 3'b000; bus16.btn = 3'b000;
      repeat (3) @(negedge clk);
   endtask

   task automatic reset_check(string name);
      rst_n = 1'b0;
      #1;
      check({name, ".led"},   32'(bus.led),   32'h0);
      check({name, ".valid"}, 32'(bus.valid), 32'h0);
      check({name, ".state"}, 32'(bus.state), 32'h0);
`ifdef ALU_FLAGS_EN
      check({name, ".zero"},  32'(bus.zero),  32'h0);
      check({name, ".carry"}, 32'(bus.carry), 32'h0);
`endif
      repeat (2) @(negedge clk);
   endtask

   initial begin
      bus.switch = '0;   bus.btn = '0;
      bus16.switch = '0; bus16.btn = '0;
      #1 rst_n = 1'b0;
      #2;
      check("reset.led",   32'(bus.led),   32'h0);
      check("reset.valid", 32'(bus.valid), 32'h0);
      check("reset.state", 32'(bus.state), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // A and B together from WAIT_A, then held 100 cycles with switch changed
      bus.switch = 8'h11; bus.btn = 3'b110;
      expect_at(4, 0, 16'h00, 0, 2'b01, 1, 0, "ab_same_cycle");
      repeat (6) @(negedge clk);
      bus.switch = 8'h22;
      repeat (94) @(negedge clk);
      expect_at(1, 0, 16'h00, 0, 2'b01, 1, 0, "held_100");
      bus.btn = 3'b000;
      repeat (3) @(negedge clk);
      press(0, 3'b001, 16'h20, 16'h11, 0, 2'b01, 0, 0, "op_in_wait_b");
      reset_check("rst_after_hold");
      rst_n = 1'b1;
      @(negedge clk);

      // Ordered load and ADD, then SUB/flag cases in DONE
      press(0, 3'b100, 16'h05, 16'h00, 0, 2'b01, 1, 0, "load_a");
      press(0, 3'b010, 16'h03, 16'h00, 0, 2'b10, 1, 0, "load_b");
      press(0, 3'b001, 16'h20, 16'h08, 1, 2'b11, 0, 0, "add_5_3");
      press(0, 3'b001, 16'h22, 16'h02, 1, 2'b11, 0, 0, "sub_5_3");
      press(0, 3'b100, 16'h03, 16'h00, 1, 2'b11, 1, 0, "sub_3_3");
      press(0, 3'b010, 16'h05, 16'hFE, 1, 2'b11, 0, 1, "sub_3_5");
      press(0, 3'b100, 16'h07, 16'h02, 1, 2'b11, 0, 0, "sub_7_5");
      press(0, 3'b010, 16'h07, 16'h00, 1, 2'b11, 1, 0, "sub_7_7");
      press(0, 3'b001, 16'h20, 16'h0E, 1, 2'b11, 0, 0, "add_7_7");
      press(0, 3'b100, 16'hF9, 16'h00, 1, 2'b11, 1, 1, "add_wrap");
      press(0, 3'b001, 16'h24, 16'h01, 1, 2'b11, 0, 0, "and");
      press(0, 3'b001, 16'h25, 16'hFF, 1, 2'b11, 0, 0, "or");
      press(0, 3'b001, 16'h26, 16'hFE, 1, 2'b11, 0, 0, "xor");
      press(0, 3'b001, 16'h27, 16'h00, 1, 2'b11, 1, 0, "nor");
      press(0, 3'b110, 16'h11, 16'hE8, 1, 2'b11, 0, 0, "prio_a_over_b");
      press(0, 3'b011, 16'h20, 16'hCE, 1, 2'b11, 0, 0, "prio_b_over_op");

      // Shifts, including shift amounts at and beyond the width
      press(0, 3'b100, 16'h09, 16'hD6, 1, 2'b11, 0, 0, "nor_a9");
      press(0, 3'b010, 16'h80, 16'h76, 1, 2'b11, 0, 0, "nor_b80");
      press(0, 3'b001, 16'h03, 16'hFF, 1, 2'b11, 0, 0, "sra_9");
      press(0, 3'b001, 16'h02, 16'h00, 1, 2'b11, 1, 0, "srl_9");
      press(0, 3'b001, 16'h3F, 16'h00, 1, 2'b11, 1, 0, "op_unknown");
      press(0, 3'b100, 16'h03, 16'h00, 1, 2'b11, 1, 0, "unknown_a3");
      press(0, 3'b001, 16'h03, 16'hF0, 1, 2'b11, 0, 0, "sra_3");
      press(0, 3'b001, 16'h02, 16'h10, 1, 2'b11, 0, 0, "srl_3");
      press(0, 3'b100, 16'h08, 16'h00, 1, 2'b11, 1, 0, "srl_8");
      press(0, 3'b001, 16'h03, 16'hFF, 1, 2'b11, 0, 0, "sra_8");
      press(0, 3'b100, 16'h07, 16'hFF, 1, 2'b11, 0, 0, "sra_7");
      press(0, 3'b001, 16'h02, 16'h01, 1, 2'b11, 0, 0, "srl_7");

      // Non-awaited opcode load in WAIT_A, then reset mid-operation in WAIT_OP
      reset_check("rst_in_done");
      rst_n = 1'b1;
      @(negedge clk);
      press(0, 3'b001, 16'h20, 16'h00, 0, 2'b00, 1, 0, "op_in_wait_a");
      press(0, 3'b100, 16'h05, 16'h05, 0, 2'b01, 0, 0, "add_a_only");
      press(0, 3'b010, 16'h03, 16'h08, 0, 2'b10, 0, 0, "add_in_wait_op");
      reset_check("rst_in_wait_op");

      // Button held through reset release gives one load
      bus.switch = 8'h44; bus.btn = 3'b100;
      @(negedge clk);
      rst_n = 1'b1;
      expect_at(4, 0, 16'h00, 0, 2'b01, 1, 0, "held_thru_reset");
      repeat (6) @(negedge clk);
      bus.switch = 8'h55;
      repeat (6) @(negedge clk);
      bus.btn = 3'b000;
      repeat (3) @(negedge clk);
      press(0, 3'b001, 16'h20, 16'h44, 0, 2'b01, 0, 0, "held_single_load");

      // 16-bit datapath with 8-bit opcode
      press(1, 3'b100, 16'h8000, 16'h0000, 0, 2'b01, 1, 0, "w16_load_a");
      press(1, 3'b010, 16'h8000, 16'h0000, 0, 2'b10, 1, 0, "w16_load_b");
      press(1, 3'b001, 16'h0020, 16'h0000, 1, 2'b11, 1, 1, "w16_add_wrap");
      press(1, 3'b001, 16'h0022, 16'h0000, 1, 2'b11, 1, 0, "w16_sub_eq");
      press(1, 3'b010, 16'h0001, 16'h7FFF, 1, 2'b11, 0, 0, "w16_sub");
      press(1, 3'b001, 16'h0003, 16'h0000, 1, 2'b11, 1, 0, "w16_sra_big_pos");
      press(1, 3'b010, 16'hF000, 16'hFFFF, 1, 2'b11, 0, 0, "w16_sra_big_neg");
      press(1, 3'b001, 16'h0002, 16'h0000, 1, 2'b11, 1, 0, "w16_srl_big");
      press(1, 3'b001, 16'h0020, 16'h7000, 1, 2'b11, 0, 1, "w16_add");
      press(1, 3'b001, 16'h00A0, 16'h0000, 1, 2'b11, 1, 0, "w16_op_ext");

      // Drain scoreboard with a bounded wait
      for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) check("scoreboard_drain", 32'(sb.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
